// File: rtl/uart_host_tx.sv
// Host-side 8N1 serial transmitter: byte FIFO, baud generator and frame serialiser with CTS flow control.
// Define UART_HOST_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_host_tx #(
    parameter int BAUD_DIV = 868,
    parameter int FIFO_AW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_ena,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             cts_n,
    output logic             txd,
    output logic             tx_busy,
    output logic [FIFO_AW:0] fifo_count,
    output logic             overflow
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(BAUD_DIV);

    localparam logic [CW-1:0]      BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0]      BAUD_ONE  = CW'(1);
    localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_HOST_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

`ifdef UART_HOST_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [FIFO_AW:0]   count_r;
    logic               overflow_r;
    state_t             state_r, state_s;
    logic [CW-1:0]      baud_r, baud_s;
    logic [2:0]         bit_r, bit_s;
    logic [7:0]         data_r, data_s;
    logic               txd_r, txd_s;
    logic               busy_r, busy_s;
    logic               pop_s;
    logic               push_s;

    assign wr_ready   = (count_r != CNT_FULL);
    assign push_s     = wr_valid & wr_ready;
    assign txd        = txd_r;
    assign tx_busy    = busy_r;
    assign fifo_count = count_r;
    assign overflow   = overflow_r;

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && clk_ena && push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Next-state, baud counter and next line value; txd is computed one cycle ahead so it leaves a flop.
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        data_s  = data_r;
        txd_s   = txd_r;
        busy_s  = busy_r;
        pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                txd_s  = 1'b1;
                busy_s = 1'b0;
                if ((count_r != '0) && !cts_n) begin
                    pop_s   = 1'b1;
                    data_s  = mem_r[rd_ptr_r];
                    baud_s  = BAUD_LAST;
                    state_s = ST_START;
                    txd_s   = 1'b0;
                    busy_s  = 1'b1;
                end else begin
                    baud_s = '0;
                end
            end
            ST_START: begin
                busy_s = 1'b1;
                txd_s  = 1'b0;
                if (baud_r == '0) begin
                    state_s = ST_DATA;
                    baud_s  = BAUD_LAST;
                    bit_s   = 3'd0;
                    txd_s   = data_r[0];
                end else begin
                    baud_s = baud_r - BAUD_ONE;
                end
            end
            ST_DATA: begin
                busy_s = 1'b1;
                txd_s  = data_r[bit_r];
                if (baud_r == '0) begin
                    baud_s = BAUD_LAST;
                    if (bit_r == 3'd7) begin
`ifdef UART_HOST_PARITY_EN
                        state_s = ST_PARITY;
                        txd_s   = even_parity(data_r);
`else
                        state_s = ST_STOP;
                        txd_s   = 1'b1;
`endif
                    end else begin
                        bit_s = bit_r + 3'd1;
                        txd_s = data_r[bit_r + 3'd1];
                    end
                end else begin
                    baud_s = baud_r - BAUD_ONE;
                end
            end
`ifdef UART_HOST_PARITY_EN
            ST_PARITY: begin
                busy_s = 1'b1;
                txd_s  = even_parity(data_r);
                if (baud_r == '0) begin
                    state_s = ST_STOP;
                    baud_s  = BAUD_LAST;
                    txd_s   = 1'b1;
                end else begin
                    baud_s = baud_r - BAUD_ONE;
                end
            end
`endif
            ST_STOP: begin
                busy_s = 1'b1;
                txd_s  = 1'b1;
                if (baud_r == '0) begin
                    state_s = ST_IDLE;
                    baud_s  = '0;
                    busy_s  = 1'b0;
                end else begin
                    baud_s = baud_r - BAUD_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                baud_s  = '0;
                txd_s   = 1'b1;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Control, FIFO bookkeeping and output registers; everything holds while clk_ena is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            baud_r     <= '0;
            bit_r      <= 3'd0;
            data_r     <= 8'h00;
            txd_r      <= 1'b1;
            busy_r     <= 1'b0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else if (clk_ena) begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            data_r  <= data_s;
            txd_r   <= txd_s;
            busy_r  <= busy_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            // A write refused for lack of space is lost; remember that it happened.
            if (wr_valid && !wr_ready) begin
                overflow_r <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_host_tx.sv
// Scoreboard bench for uart_host_tx: writes push expected bytes, a line monitor decodes and checks every frame.
`timescale 1ns/1ps
module tb_uart_host_tx;
    localparam int BD = 4;
    localparam int AW = 4;
`ifdef UART_HOST_PARITY_EN
    localparam int NB = 11;
    localparam logic [NB-1:0] F55 = 11'b10010101010;
    localparam logic [NB-1:0] FA3 = 11'b10101000110;
    localparam logic [NB-1:0] F0F = 11'b10000011110;
    localparam logic [NB-1:0] F41 = 11'b10010000010;
    localparam logic [NB-1:0] F81 = 11'b10100000010;
    localparam logic [NB-1:0] F07 = 11'b11000001110;
`else
    localparam int NB = 10;
    localparam logic [NB-1:0] F55 = 10'b1010101010;
    localparam logic [NB-1:0] FA3 = 10'b1101000110;
    localparam logic [NB-1:0] F0F = 10'b1000011110;
    localparam logic [NB-1:0] F41 = 10'b1010000010;
    localparam logic [NB-1:0] F81 = 10'b1100000010;
    localparam logic [NB-1:0] F07 = 10'b1000001110;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk_ena = 1'b1;
    logic [7:0]    wr_data = 8'h00;
    logic          wr_valid = 1'b0;
    logic          cts_n = 1'b0;
    logic          wr_ready, txd, tx_busy, overflow;
    logic [AW:0]   fifo_count;

    int            checks = 0;
    int            failures = 0;
    int            frames_done = 0;
    int            last_gap = 0;
    logic [7:0]    exp_q [$];
    logic [NB-1:0] cap_q [$];
    logic          en_seen = 1'b0;
    logic          rst_seen = 1'b0;
    logic          toggle_en = 1'b0;

    always #5 clk = ~clk;

    uart_host_tx #(.BAUD_DIV(BD), .FIFO_AW(AW)) dut (
        .clk(clk), .rst(rst), .clk_ena(clk_ena), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .cts_n(cts_n), .txd(txd), .tx_busy(tx_busy),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always @(posedge clk) begin
        en_seen  <= clk_ena;
        rst_seen <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] mk_frame(input logic [7:0] b);
        logic [NB-1:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_HOST_PARITY_EN
        f[9] = ^b;
`endif
        f[NB-1] = 1'b1;
        return f;
    endfunction

    task automatic push_byte(input logic [7:0] b, input bit accepted);
        if (accepted) exp_q.push_back(b);
        wr_data  = b;
        wr_valid = 1'b1;
        do begin
            @(posedge clk);
            #1;
        end while (!en_seen);
        wr_valid = 1'b0;
    endtask

    task automatic wait_frames(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, frames_done, target);
    endtask

    task automatic check_cap(input string name, input logic [NB-1:0] want);
        logic [NB-1:0] got;
        got = 'x;
        if (cap_q.size() != 0) got = cap_q.pop_front();
        check(name, 32'(got), 32'(want));
    endtask

    task automatic measure_busy(input string name, input int want);
        int n, g;
        g = 0;
        while (tx_busy !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        n = 0;
        g = 0;
        while (tx_busy === 1'b1 && g < 1000) begin
            n++;
            g++;
            @(negedge clk);
        end
        check(name, n, want);
    endtask

    initial begin : enable_driver
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) clk_ena = ~clk_ena;
            else clk_ena = 1'b1;
        end
    end

    // Line monitor: decodes each frame on enabled cycles and compares it against the expected-byte queue.
    initial begin : line_monitor
        logic          in_frame, slot_bad, bad_val;
        int            bitpos, slot, idle_run;
        logic [NB-1:0] want, got;
        in_frame = 1'b0; slot_bad = 1'b0; bad_val = 1'b0;
        bitpos = 0; slot = 0; idle_run = 0; want = '0; got = '0;
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                in_frame = 1'b0;
                idle_run = 0;
            end else if (en_seen) begin
                if (!in_frame) begin
                    if (txd === 1'b0) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL unexpected_frame actual=start_bit required=idle_line");
                            want = mk_frame(8'h00);
                        end else begin
                            want = mk_frame(exp_q.pop_front());
                        end
                        in_frame = 1'b1; bitpos = 0; slot = 0; slot_bad = 1'b0;
                        last_gap = idle_run; got = '0;
                    end else begin
                        check("idle_busy", 32'(tx_busy), 32'd0);
                        idle_run++;
                    end
                end
                if (in_frame) begin
                    if (slot == 0) got[bitpos] = txd;
                    if (txd !== want[bitpos] || tx_busy !== 1'b1) begin
                        if (!slot_bad) bad_val = txd;
                        slot_bad = 1'b1;
                    end
                    slot++;
                    if (slot == BD) begin
                        checks++;
                        if (slot_bad) begin
                            failures++;
                            $display("FAIL frame_bit%0d actual=%b required=%b busy=%b", bitpos, bad_val, want[bitpos], tx_busy);
                        end
                        slot = 0; slot_bad = 1'b0; bitpos++;
                        if (bitpos == NB) begin
                            in_frame = 1'b0;
                            idle_run = 0;
                            cap_q.push_back(got);
                            frames_done++;
                        end
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int base;
        logic saw_low;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);

        // single byte with latency and frame length
        push_byte(8'h55, 1'b1);
        @(negedge clk);
        check("lat_count1", 32'(fifo_count), 32'd1);
        check("lat_txd_idle", 32'(txd), 32'd1);
        @(negedge clk);
        check("lat_count0", 32'(fifo_count), 32'd0);
        check("lat_txd_start", 32'(txd), 32'd0);
        measure_busy("busy_len_55", NB * BD);
        wait_frames("frame_55_done", 1, 50);
        check_cap("frame_55", F55);

        // back-to-back
        base = frames_done;
        push_byte(8'hA3, 1'b1);
        push_byte(8'h0F, 1'b1);
        wait_frames("b2b_done", base + 2, 2 * NB * BD + 50);
        check("b2b_gap", last_gap, 1);
        check_cap("frame_A3", FA3);
        check_cap("frame_0F", F0F);

        // flow control
        base = frames_done;
        cts_n = 1'b1;
        push_byte(8'h41, 1'b1);
        saw_low = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (txd !== 1'b1) saw_low = 1'b1;
        end
        check("cts_hold_txd", 32'(saw_low), 32'd0);
        check("cts_hold_count", 32'(fifo_count), 32'd1);
        cts_n = 1'b0;
        @(negedge clk);
        check("cts_release_start", 32'(txd), 32'd0);
        repeat (14) @(negedge clk);
        cts_n = 1'b1;
        wait_frames("cts_done", base + 1, NB * BD + 50);
        check_cap("frame_41", F41);
        check("cts_count0", 32'(fifo_count), 32'd0);

        // full and overflow
        base = frames_done;
        for (int i = 0; i < 17; i++) begin
            push_byte(8'(i), i < 16);
            if (i == 15) begin
                @(negedge clk);
                check("full_count", 32'(fifo_count), 32'd16);
                check("full_wr_ready", 32'(wr_ready), 32'd0);
                check("full_overflow", 32'(overflow), 32'd0);
            end
        end
        @(negedge clk);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(fifo_count), 32'd16);
        cts_n = 1'b0;
        wait_frames("drain_done", base + 16, 16 * (NB * BD + 1) + 50);
        check("drain_queue_left", exp_q.size(), 0);
        repeat (3 * NB * BD) @(negedge clk);
        check("no_extra_frame", frames_done, base + 16);
        check("drain_count", 32'(fifo_count), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        cap_q.delete();

        // reset mid-frame
        push_byte(8'hFF, 1'b1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_txd", 32'(txd), 32'd1);
        check("abort_busy", 32'(tx_busy), 32'd0);
        check("abort_count", 32'(fifo_count), 32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        check("abort_no_capture", cap_q.size(), 0);

        // clock enable toggling
        base = frames_done;
        toggle_en = 1'b1;
        push_byte(8'h81, 1'b1);
        measure_busy("busy_len_toggle", 2 * NB * BD);
        wait_frames("toggle_done", base + 1, 100);
        check_cap("frame_81", F81);
        toggle_en = 1'b0;
        repeat (3) @(negedge clk);

        // 0x07 exercises the parity bit when that option is built in
        base = frames_done;
        push_byte(8'h07, 1'b1);
        measure_busy("busy_len_07", NB * BD);
        wait_frames("frame_07_done", base + 1, 50);
        check_cap("frame_07", F07);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
